// File: rtl/dcf77_clock_if.sv
// Bundle between the DCF77 frame receiver and the free-running calendar clock.
// The receiver side (master) supplies the tick enable and validated frame;
// the clock side (slave) returns the BCD time/date and lock status.
interface dcf77_clock_if;
  logic        clk_en;
  logic [58:0] data_hold;
  logic        sync;
  logic [6:0]  sec_bcd;
  logic [6:0]  min_bcd;
  logic [5:0]  hour_bcd;
  logic [5:0]  day_bcd;
  logic [2:0]  wday;
  logic [4:0]  month_bcd;
  logic [7:0]  year_bcd;
  logic        sec_tick;
  logic        time_valid;
  logic        locked;

  modport master (
    output clk_en, data_hold, sync,
    input  sec_bcd, min_bcd, hour_bcd, day_bcd, wday, month_bcd, year_bcd,
    input  sec_tick, time_valid, locked
  );

  modport slave (
    input  clk_en, data_hold, sync,
    output sec_bcd, min_bcd, hour_bcd, day_bcd, wday, month_bcd, year_bcd,
    output sec_tick, time_valid, locked
  );
endinterface

// File: rtl/dcf77_clock.sv
// BCD time/date keeper behind the DCF77 receiver. Each sync strobe loads the
// decoded frame; between syncs the clock free-runs from the 10 ms tick with
// full calendar carry, and a holdover counter drops 'locked' after too many
// minutes without a fresh frame.
module dcf77_clock #(
  parameter int TICKS_PER_SEC = 100,
  parameter int HOLDOVER_MIN  = 1440
) (
  input  logic          clk,
  input  logic          reset,
  dcf77_clock_if.slave  bus
);

  localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HO_W = $clog2(HOLDOVER_MIN + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [HO_W-1:0] HO_MAX  = HO_W'(HOLDOVER_MIN);

  // Two-digit BCD increment; callers handle their own field wrap values.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Leap year straight from BCD digits: a multiple of 4 within 00..99.
  function automatic logic is_leap(input logic [7:0] y);
    logic tens_even;
    logic u048;
    logic u26;
    tens_even = ~y[4];
    u048 = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    u26  = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    return (tens_even && u048) || (!tens_even && u26);
  endfunction

  // Last day of the month in BCD.
  function automatic logic [7:0] last_day(input logic [4:0] m, input logic [7:0] y);
    logic [7:0] r;
    case (m)
      5'h01, 5'h03, 5'h05, 5'h07, 5'h08, 5'h10, 5'h12: r = 8'h31;
      5'h04, 5'h06, 5'h09, 5'h11:                      r = 8'h30;
      5'h02:   r = is_leap(y) ? 8'h29 : 8'h28;
      default: r = 8'h31;
    endcase
    return r;
  endfunction

  logic [6:0]      sec_q,   sec_d;
  logic [6:0]      min_q,   min_d;
  logic [5:0]      hour_q,  hour_d;
  logic [5:0]      day_q,   day_d;
  logic [2:0]      wday_q,  wday_d;
  logic [4:0]      month_q, month_d;
  logic [7:0]      year_q,  year_d;
  logic [PS_W-1:0] prescale_q, prescale_d;
  logic [HO_W-1:0] hold_q,  hold_d;
  logic            sec_tick_q, sec_tick_d;
  logic            time_valid_q, time_valid_d;
  logic            locked_q, locked_d;

  logic [7:0]      sec_inc_s, min_inc_s, hour_inc_s, day_inc_s, month_inc_s, year_inc_s;
  logic [7:0]      last_day_s;
  logic [HO_W-1:0] hold_inc_s;
  logic            unused_bits_s;

  assign sec_inc_s   = bcd_inc({1'b0, sec_q});
  assign min_inc_s   = bcd_inc({1'b0, min_q});
  assign hour_inc_s  = bcd_inc({2'b00, hour_q});
  assign day_inc_s   = bcd_inc({2'b00, day_q});
  assign month_inc_s = bcd_inc({3'b000, month_q});
  assign year_inc_s  = bcd_inc(year_q);
  assign last_day_s  = last_day(month_q, year_q);
  assign hold_inc_s  = (hold_q == HO_MAX) ? hold_q : hold_q + HO_W'(1);

  // Frame bits carrying markers/parity and always-zero high digits are not needed here.
  assign unused_bits_s = ^{bus.data_hold[20:0], bus.data_hold[28], bus.data_hold[35],
                           bus.data_hold[58], sec_inc_s[7], min_inc_s[7], hour_inc_s[7:6],
                           day_inc_s[7:6], month_inc_s[7:5]};

  // Next-state: sync load has priority over the prescaler wrap and its carry chain.
  always_comb begin
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    day_d        = day_q;
    wday_d       = wday_q;
    month_d      = month_q;
    year_d       = year_q;
    prescale_d   = prescale_q;
    hold_d       = hold_q;
    sec_tick_d   = 1'b0;
    time_valid_d = time_valid_q;
    locked_d     = locked_q;
    if (bus.clk_en) begin
      if (bus.sync) begin
        sec_d        = 7'h00;
        min_d        = bus.data_hold[27:21];
        hour_d       = bus.data_hold[34:29];
        day_d        = bus.data_hold[41:36];
        wday_d       = bus.data_hold[44:42];
        month_d      = bus.data_hold[49:45];
        year_d       = bus.data_hold[57:50];
        prescale_d   = '0;
        hold_d       = '0;
        sec_tick_d   = 1'b1;
        time_valid_d = 1'b1;
        locked_d     = 1'b1;
      end else if (prescale_q == PS_LAST) begin
        prescale_d = '0;
        sec_tick_d = 1'b1;
        if (sec_q == 7'h59) begin
          sec_d  = 7'h00;
          hold_d = hold_inc_s;
          if (hold_inc_s == HO_MAX) begin
            locked_d = 1'b0;
          end else begin
            locked_d = locked_q;
          end
          if (min_q == 7'h59) begin
            min_d = 7'h00;
            if (hour_q == 6'h23) begin
              hour_d = 6'h00;
              wday_d = (wday_q == 3'd7) ? 3'd1 : wday_q + 3'd1;
              if ({2'b00, day_q} == last_day_s) begin
                day_d = 6'h01;
                if (month_q == 5'h12) begin
                  month_d = 5'h01;
                  year_d  = (year_q == 8'h99) ? 8'h00 : year_inc_s;
                end else begin
                  month_d = month_inc_s[4:0];
                end
              end else begin
                day_d = day_inc_s[5:0];
              end
            end else begin
              hour_d = hour_inc_s[5:0];
            end
          end else begin
            min_d = min_inc_s[6:0];
          end
        end else begin
          sec_d = sec_inc_s[6:0];
        end
      end else begin
        prescale_d = prescale_q + PS_W'(1);
      end
    end else begin
      sec_tick_d = 1'b0;
    end
  end

  // State registers with synchronous reset to 00:00:00 Mon 01.01.00, unlocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q        <= 7'h00;
      min_q        <= 7'h00;
      hour_q       <= 6'h00;
      day_q        <= 6'h01;
      wday_q       <= 3'd1;
      month_q      <= 5'h01;
      year_q       <= 8'h00;
      prescale_q   <= '0;
      hold_q       <= '0;
      sec_tick_q   <= 1'b0;
      time_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      day_q        <= day_d;
      wday_q       <= wday_d;
      month_q      <= month_d;
      year_q       <= year_d;
      prescale_q   <= prescale_d;
      hold_q       <= hold_d;
      sec_tick_q   <= sec_tick_d;
      time_valid_q <= time_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.sec_bcd    = sec_q;
  assign bus.min_bcd    = min_q;
  assign bus.hour_bcd   = hour_q;
  assign bus.day_bcd    = day_q;
  assign bus.wday       = wday_q;
  assign bus.month_bcd  = month_q;
  assign bus.year_bcd   = year_q;
  assign bus.sec_tick   = sec_tick_q;
  assign bus.time_valid = time_valid_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_dcf77_clock.sv
// Directed bench for dcf77_clock: calendar carry, leap years, resync, holdover, reset.
module tb_dcf77_clock;
  logic clk;
  logic reset;
  int   checks   = 0;
  int   fails    = 0;
  int   tick_cnt = 0;

  dcf77_clock_if bm();
  dcf77_clock_if bh();

  dcf77_clock #(.TICKS_PER_SEC(100), .HOLDOVER_MIN(1440)) dut (
    .clk(clk), .reset(reset), .bus(bm)
  );

  dcf77_clock #(.TICKS_PER_SEC(100), .HOLDOVER_MIN(2)) dut_h (
    .clk(clk), .reset(reset), .bus(bh)
  );

  localparam logic [44:0] RST_EXP = {7'h00, 7'h00, 6'h00, 6'h01, 3'd1, 5'h01, 8'h00, 1'b0, 1'b0, 1'b0};

  wire [44:0] snap = {bm.sec_bcd, bm.min_bcd, bm.hour_bcd, bm.day_bcd, bm.wday, bm.month_bcd,
                      bm.year_bcd, bm.sec_tick, bm.time_valid, bm.locked};
  wire [19:0] bm_time = {bm.hour_bcd, bm.min_bcd, bm.sec_bcd};
  wire [18:0] bm_date = {bm.day_bcd, bm.month_bcd, bm.year_bcd};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [58:0] mk(input logic [7:0] mi, input logic [7:0] hr, input logic [7:0] dy,
                                     input logic [2:0] wd, input logic [7:0] mo, input logic [7:0] yr);
    logic [58:0] f;
    f = '0;
    f[20]    = 1'b1;
    f[28]    = 1'b1;
    f[35]    = 1'b1;
    f[58]    = 1'b1;
    f[27:21] = mi[6:0];
    f[34:29] = hr[5:0];
    f[41:36] = dy[5:0];
    f[44:42] = wd;
    f[49:45] = mo[4:0];
    f[57:50] = yr;
    return f;
  endfunction

  task automatic run(input int n);
    bm.clk_en = 1'b1;
    bh.clk_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bm.sec_tick === 1'b1) tick_cnt++;
    end
    bm.clk_en = 1'b0;
    bh.clk_en = 1'b0;
  endtask

  task automatic do_sync(input int sel, input logic [58:0] f);
    bm.clk_en = 1'b1;
    bh.clk_en = 1'b1;
    if (sel == 0) begin
      bm.sync = 1'b1;
      bm.data_hold = f;
    end else begin
      bh.sync = 1'b1;
      bh.data_hold = f;
    end
    @(posedge clk);
    @(negedge clk);
    bm.sync = 1'b0;
    bh.sync = 1'b0;
    bm.clk_en = 1'b0;
    bh.clk_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bm.clk_en = 1'b0; bm.sync = 1'b0; bm.data_hold = '0;
    bh.clk_en = 1'b0; bh.sync = 1'b0; bh.data_hold = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (snap !== RST_EXP) begin
      fails++; $display("FAIL reset_values: got %h expected %h", snap, RST_EXP);
    end
  endtask

  task automatic test_free_run();
    tick_cnt = 0;
    run(100);
    checks++;
    if ({bm_time, tick_cnt} !== {6'h00, 7'h00, 7'h01, 32'd1}) begin
      fails++; $display("FAIL free_run: got time %h ticks %0d expected 000001 ticks 1", bm_time, tick_cnt);
    end
    checks++;
    if ({bm.time_valid, bm.locked} !== 2'b00) begin
      fails++; $display("FAIL free_run_status: got %b expected 00", {bm.time_valid, bm.locked});
    end
  endtask

  task automatic test_year_wrap();
    do_sync(0, mk(8'h59, 8'h23, 8'h31, 3'd5, 8'h12, 8'h99));
    checks++;
    if ({bm_time, bm_date, bm.wday} !== {6'h23, 7'h59, 7'h00, 6'h31, 5'h12, 8'h99, 3'd5}) begin
      fails++; $display("FAIL sync_load: got %h %h wday %0d expected 235900 311299 wday 5", bm_time, bm_date, bm.wday);
    end
    checks++;
    if ({bm.sec_tick, bm.time_valid, bm.locked} !== 3'b111) begin
      fails++; $display("FAIL sync_flags: got %b expected 111", {bm.sec_tick, bm.time_valid, bm.locked});
    end
    tick_cnt = 0;
    run(6000);
    checks++;
    if (bm_time !== {6'h00, 7'h00, 7'h00}) begin
      fails++; $display("FAIL yw_time: got %h expected 000000", bm_time);
    end
    checks++;
    if ({bm_date, bm.wday} !== {6'h01, 5'h01, 8'h00, 3'd6}) begin
      fails++; $display("FAIL yw_date: got %h wday %0d expected 010100 wday 6", bm_date, bm.wday);
    end
    checks++;
    if (tick_cnt !== 60) begin
      fails++; $display("FAIL yw_ticks: got %0d expected 60", tick_cnt);
    end
    checks++;
    if (bm.locked !== 1'b1) begin
      fails++; $display("FAIL yw_locked: got %b expected 1", bm.locked);
    end
  endtask

  task automatic test_leap_feb();
    do_sync(0, mk(8'h59, 8'h23, 8'h28, 3'd3, 8'h02, 8'h24));
    run(6000);
    checks++;
    if ({bm_date, bm.wday} !== {6'h29, 5'h02, 8'h24, 3'd4}) begin
      fails++; $display("FAIL leap_28_24: got %h wday %0d expected 290224 wday 4", bm_date, bm.wday);
    end
    do_sync(0, mk(8'h59, 8'h23, 8'h29, 3'd4, 8'h02, 8'h24));
    run(6000);
    checks++;
    if (bm_date !== {6'h01, 5'h03, 8'h24}) begin
      fails++; $display("FAIL leap_29_24: got %h expected 010324", bm_date);
    end
    do_sync(0, mk(8'h59, 8'h23, 8'h28, 3'd2, 8'h02, 8'h23));
    run(6000);
    checks++;
    if (bm_date !== {6'h01, 5'h03, 8'h23}) begin
      fails++; $display("FAIL nonleap_28_23: got %h expected 010323", bm_date);
    end
  endtask

  task automatic test_resync_mid_second();
    do_sync(0, mk(8'h14, 8'h10, 8'h05, 3'd1, 8'h05, 8'h25));
    run(4237);
    checks++;
    if (bm_time !== {6'h10, 7'h14, 7'h42}) begin
      fails++; $display("FAIL resync_pre: got %h expected 101442", bm_time);
    end
    do_sync(0, mk(8'h15, 8'h10, 8'h05, 3'd1, 8'h05, 8'h25));
    checks++;
    if (bm_time !== {6'h10, 7'h15, 7'h00}) begin
      fails++; $display("FAIL resync_load: got %h expected 101500", bm_time);
    end
    tick_cnt = 0;
    run(99);
    checks++;
    if ({tick_cnt, bm.sec_bcd} !== {32'd0, 7'h00}) begin
      fails++; $display("FAIL resync_99: got ticks %0d sec %h expected ticks 0 sec 00", tick_cnt, bm.sec_bcd);
    end
    run(1);
    checks++;
    if ({tick_cnt, bm.sec_tick, bm.sec_bcd} !== {32'd1, 1'b1, 7'h01}) begin
      fails++; $display("FAIL resync_100: got ticks %0d pulse %b sec %h expected ticks 1 pulse 1 sec 01",
                        tick_cnt, bm.sec_tick, bm.sec_bcd);
    end
  endtask

  task automatic test_sync_on_wrap();
    do_sync(0, mk(8'h30, 8'h07, 8'h10, 3'd3, 8'h07, 8'h25));
    run(5999);
    checks++;
    if (bm_time !== {6'h07, 7'h30, 7'h59}) begin
      fails++; $display("FAIL wrap_pre: got %h expected 073059", bm_time);
    end
    do_sync(0, mk(8'h45, 8'h08, 8'h10, 3'd3, 8'h07, 8'h25));
    checks++;
    if (bm_time !== {6'h08, 7'h45, 7'h00}) begin
      fails++; $display("FAIL wrap_sync: got %h expected 084500", bm_time);
    end
  endtask

  task automatic test_holdover();
    do_sync(1, mk(8'h00, 8'h12, 8'h01, 3'd1, 8'h01, 8'h25));
    checks++;
    if (bh.locked !== 1'b1) begin
      fails++; $display("FAIL ho_sync: got %b expected 1", bh.locked);
    end
    run(6000);
    checks++;
    if ({bh.locked, bh.min_bcd} !== {1'b1, 7'h01}) begin
      fails++; $display("FAIL ho_1201: got %b %h expected 1 01", bh.locked, bh.min_bcd);
    end
    run(5999);
    checks++;
    if ({bh.locked, bh.min_bcd, bh.sec_bcd} !== {1'b1, 7'h01, 7'h59}) begin
      fails++; $display("FAIL ho_120159: got %b %h %h expected 1 01 59", bh.locked, bh.min_bcd, bh.sec_bcd);
    end
    run(1);
    checks++;
    if ({bh.locked, bh.hour_bcd, bh.min_bcd, bh.sec_bcd} !== {1'b0, 6'h12, 7'h02, 7'h00}) begin
      fails++; $display("FAIL ho_120200: got %b %h %h %h expected 0 12 02 00",
                        bh.locked, bh.hour_bcd, bh.min_bcd, bh.sec_bcd);
    end
    run(6000);
    checks++;
    if ({bh.locked, bh.min_bcd, bh.time_valid} !== {1'b0, 7'h03, 1'b1}) begin
      fails++; $display("FAIL ho_stays: got %b %h %b expected 0 03 1", bh.locked, bh.min_bcd, bh.time_valid);
    end
    do_sync(1, mk(8'h10, 8'h12, 8'h01, 3'd1, 8'h01, 8'h25));
    checks++;
    if (bh.locked !== 1'b1) begin
      fails++; $display("FAIL ho_relock: got %b expected 1", bh.locked);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    do_sync(0, mk(8'h33, 8'h14, 8'h15, 3'd2, 8'h06, 8'h25));
    run(2700);
    checks++;
    if ({bm_time, bm.locked} !== {6'h14, 7'h33, 7'h27, 1'b1}) begin
      fails++; $display("FAIL rst_pre: got %h %b expected 143327 1", bm_time, bm.locked);
    end
    reset = 1'b1;
    bm.clk_en = 1'b1;
    bh.clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bm.clk_en = 1'b0;
    bh.clk_en = 1'b0;
    checks++;
    if (snap !== RST_EXP) begin
      fails++; $display("FAIL rst_mid: got %h expected %h", snap, RST_EXP);
    end
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (snap !== RST_EXP) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL rst_frozen: got %0d changed cycles expected 0", bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_free_run();
    test_year_wrap();
    test_leap_feb();
    test_resync_mid_second();
    test_sync_on_wrap();
    test_holdover();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
